// File: rtl/imem_boot_arbiter.sv
// -----------------------------------------------------------------------------
// imem_boot_arbiter
//
// Owns the single port of the instruction memory. The port is shared between
// the core fetch path and a program loader.
//
// After reset the block sits in LOAD. The core is held there while the loader
// fills memory. ld_done releases the core into RUN. In RUN, fetch normally wins
// the port. A loader write that is blocked for STARVE_MAX cycles takes the port
// for one cycle. ld_reload passes through a one-cycle QUIESCE, which lets an
// outstanding fetch response drain, and then returns to LOAD.
//
// Memory index is addr[31:2]. Addresses whose index is >= DEPTH are accepted.
// They never touch memory: a fetch returns instr=0 with fetch_fault, and a
// loader write is dropped and sets the sticky ld_err.
//
// Ports
//   clk, rst                  clock; asynchronous active-low reset
//   fetch_req/addr/ready      fetch request channel (ready = accepted this cycle)
//   fetch_valid/instr/fault   fetch response, one cycle after acceptance
//   ld_valid/addr/data/ready  loader write channel
//   ld_done, ld_reload        leave LOAD / re-enter LOAD (pulses)
//   ld_err, ld_count          sticky drop flag; accepted in-range write count
//   core_run                  core may execute
//   mem_we/addr/wdata/rdata   memory port (synchronous read, 1-cycle latency)
// -----------------------------------------------------------------------------
module imem_boot_arbiter #(
    parameter int DEPTH      = 1024,
    parameter int IDX_W      = $clog2(DEPTH),
    parameter int STARVE_MAX = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fetch_req,
    input  logic [31:0]      fetch_addr,
    output logic             fetch_ready,
    output logic             fetch_valid,
    output logic [31:0]      fetch_instr,
    output logic             fetch_fault,
    input  logic             ld_valid,
    input  logic [31:0]      ld_addr,
    input  logic [31:0]      ld_data,
    output logic             ld_ready,
    input  logic             ld_done,
    input  logic             ld_reload,
    output logic             ld_err,
    output logic [IDX_W:0]   ld_count,
    output logic             core_run,
    output logic             mem_we,
    output logic [IDX_W-1:0] mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata
);

    localparam int          SC_W    = $clog2(STARVE_MAX + 1);
    localparam int          CNT_W   = IDX_W + 1;
    localparam logic [29:0] DEPTH_W = 30'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);
    localparam logic [SC_W-1:0]  SC_MAX  = SC_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_RUN,
        ST_QUIESCE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [SC_W-1:0]  starve_cnt;
    logic             starve;
    logic             fetch_in_range;
    logic             ld_in_range;
    logic             ld_accept;
    logic             fv_q;         // a fetch was accepted last cycle
    logic             ff_q;         // ...and it was out of range
    logic [IDX_W-1:0] addr_q;       // last address driven, held while idle

    // The byte-offset bits are intentionally ignored. They are folded here so
    // that nothing appears undriven or unused.
    logic unused_ok;
    assign unused_ok = ^{fetch_addr[1:0], ld_addr[1:0]};

    assign fetch_in_range = fetch_addr[31:2] < DEPTH_W;
    assign ld_in_range    = ld_addr[31:2] < DEPTH_W;
    assign starve         = (starve_cnt == SC_MAX);

    // -------------------------------------------------------------------------
    // Next state and grants
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default before the case
        // statement, so no path can leave a signal unassigned and infer a latch.
        state_nxt   = state;
        fetch_ready = 1'b0;
        ld_ready    = 1'b0;
        core_run    = 1'b0;
        unique case (state)
            ST_LOAD: begin
                ld_ready = 1'b1;
                if (ld_done) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                core_run = 1'b1;
                // A reload request blocks all grants in the cycle it arrives.
                if (ld_reload) begin
                    state_nxt = ST_QUIESCE;
                end else begin
                    fetch_ready = fetch_req & ~starve;
                    ld_ready    = ld_valid & (~fetch_req | starve);
                end
            end
            ST_QUIESCE: state_nxt = ST_LOAD;
            default:    state_nxt = ST_LOAD;
        endcase
    end

    assign ld_accept = ld_valid & ld_ready;

    // -------------------------------------------------------------------------
    // Memory port: at most one grant per cycle, so the mux has no conflict.
    // An out-of-range fetch does not move the address.
    // -------------------------------------------------------------------------
    always_comb begin
        mem_we    = ld_accept & ld_in_range;
        mem_wdata = mem_we ? ld_data : 32'h0;
        if (mem_we)
            mem_addr = ld_addr[IDX_W+1:2];
        else if (fetch_ready && fetch_in_range)
            mem_addr = fetch_addr[IDX_W+1:2];
        else
            mem_addr = addr_q;
    end

    // Response comes from the memory's registered read data. It is forced to 0
    // when the response is a fault or when no response is pending.
    assign fetch_valid = fv_q;
    assign fetch_fault = fv_q & ff_q;
    assign fetch_instr = (fv_q && !ff_q) ? mem_rdata : 32'h0;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments only. All
        // registers then update together at the edge, regardless of the order
        // in which the statements are written.
        if (!rst) begin
            state      <= ST_LOAD;
            starve_cnt <= '0;
            fv_q       <= 1'b0;
            ff_q       <= 1'b0;
            addr_q     <= '0;
            ld_err     <= 1'b0;
            ld_count   <= '0;
        end else begin
            state  <= state_nxt;
            fv_q   <= fetch_ready;
            ff_q   <= fetch_ready & ~fetch_in_range;
            addr_q <= mem_addr;

            if (ld_accept && !ld_in_range) ld_err <= 1'b1;

            // QUIESCE always exits to LOAD, so clearing here is the LOAD entry.
            if (state == ST_QUIESCE)
                ld_count <= '0;
            else if (mem_we && ld_count != CNT_MAX)
                ld_count <= ld_count + CNT_W'(1);

            if (ld_accept)
                starve_cnt <= '0;
            else if (state == ST_RUN && ld_valid && !starve)
                starve_cnt <= starve_cnt + SC_W'(1);
        end
    end

endmodule
